// File: rtl/leaky_integrate_fire_neuron.sv
// Leaky integrate-and-fire neuron: 8-bit signed membrane potential with shift-based leak,
// saturating integration, threshold firing and an enabled-step refractory down-counter.
module leaky_integrate_fire_neuron (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic signed [7:0] input_current,
  input  logic        [7:0] threshold,
  input  logic        [2:0] decay_shift,
  input  logic        [7:0] refractory_period,
  output logic              spike_out,
  output logic signed [7:0] membrane_potential,
  output logic              refractory
);

  // state         | meaning
  // ST_INTEGRATE  | accumulate leaked potential plus input current, fire at threshold
  // ST_REFRACTORY | ignore input for ref_cnt enabled steps, V held at 0
  typedef enum logic {ST_INTEGRATE, ST_REFRACTORY} state_t;

  state_t             r_state;
  logic        [7:0]  r_ref_cnt;
  logic signed [7:0]  r_v;
  logic               r_spike;

  logic signed [7:0]  w_leak;
  logic signed [9:0]  w_sum;
  logic signed [7:0]  w_v_next;
  logic signed [9:0]  w_v_next_ext;
  logic signed [9:0]  w_thr_ext;
  logic               w_fire;

  // A shift of 0 must mean no leak, not a leak equal to V.
  assign w_leak = (decay_shift == 3'd0) ? 8'sd0 : (r_v >>> decay_shift);

  assign w_sum = {{2{r_v[7]}}, r_v} - {{2{w_leak[7]}}, w_leak}
               + {{2{input_current[7]}}, input_current};

  always_comb begin
    w_v_next = w_sum[7:0];
    if (!w_sum[9] && (w_sum[8:7] != 2'b00))
      w_v_next = 8'sd127;
    else if (w_sum[9] && (w_sum[8:7] != 2'b11))
      w_v_next = -8'sd128;
  end

  assign w_v_next_ext = {{2{w_v_next[7]}}, w_v_next};
  assign w_thr_ext    = {2'b00, threshold};
  assign w_fire       = (w_v_next_ext >= w_thr_ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INTEGRATE;
      r_ref_cnt <= 8'd0;
      r_v       <= 8'sd0;
      r_spike   <= 1'b0;
    end else begin
      r_spike <= 1'b0;
      if (enable) begin
        case (r_state)
          ST_INTEGRATE: begin
            if (w_fire) begin
              r_spike <= 1'b1;
              r_v     <= 8'sd0;
              if (refractory_period != 8'd0) begin
                r_state   <= ST_REFRACTORY;
                r_ref_cnt <= refractory_period;
              end
            end else begin
              r_v <= w_v_next;
            end
          end
          ST_REFRACTORY: begin
            r_v       <= 8'sd0;
            r_ref_cnt <= r_ref_cnt - 8'd1;
            if (r_ref_cnt <= 8'd1)
              r_state <= ST_INTEGRATE;
          end
          default: r_state <= ST_INTEGRATE;
        endcase
      end
    end
  end

  assign spike_out          = r_spike;
  assign membrane_potential = r_v;
  assign refractory         = (r_state == ST_REFRACTORY);

endmodule
